// File: rtl/demux_1x2_buffered_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_1x2_buffered_if                                                |
// | Stream bundle for the buffered 1-to-2 demultiplexer: one producer    |
// | side and two consumer channels, each with valid/ready handshakes.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface demux_1x2_buffered_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic             auto_mode;
    logic [WIDTH-1:0] out_0_data;
    logic             out_0_valid;
    logic             out_0_ready;
    logic [WIDTH-1:0] out_1_data;
    logic             out_1_valid;
    logic             out_1_ready;

    // Environment side: producer plus both consumers.
    modport master (
        output in_data, in_valid, sel, auto_mode, out_0_ready, out_1_ready,
        input  in_ready, out_0_data, out_0_valid, out_1_data, out_1_valid
    );

    // Demultiplexer side.
    modport slave (
        input  in_data, in_valid, sel, auto_mode, out_0_ready, out_1_ready,
        output in_ready, out_0_data, out_0_valid, out_1_data, out_1_valid
    );
endinterface
`default_nettype wire

// File: rtl/demux_1x2_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_1x2_buffered                                                   |
// | Steers each accepted input beat into one of two 2-entry FIFOs,       |
// | chosen by sel or by an alternating pointer in auto mode. Counts      |
// | input stall cycles in a saturating 8-bit counter.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module demux_1x2_buffered #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    demux_1x2_buffered_if.slave   bus,
    output logic [7:0]            drop_cnt
);
    localparam logic [1:0] C_FULL = 2'd2;

    logic [WIDTH-1:0] mem    [2][2];
    logic [1:0]       cnt    [2];
    logic             rd_ptr [2];
    logic             wr_ptr [2];
    logic             rr_ptr;

    logic             tgt;
    logic             in_ready_w;
    logic             accept;
    logic             push   [2];
    logic             pop    [2];
    logic             out_rdy[2];

    // Target selection, acceptance and per-channel push/pop strobes.
    // A full target refuses input even if it is popped this cycle.
    always_comb begin
        tgt        = bus.auto_mode ? rr_ptr : bus.sel;
        in_ready_w = (cnt[tgt] != C_FULL);
        accept     = bus.in_valid && in_ready_w;
        out_rdy[0] = bus.out_0_ready;
        out_rdy[1] = bus.out_1_ready;
        push[0]    = accept && !tgt;
        push[1]    = accept &&  tgt;
        for (int k = 0; k < 2; k++) begin
            pop[k] = (cnt[k] != 2'd0) && out_rdy[k];
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_0_valid = (cnt[0] != 2'd0);
    assign bus.out_1_valid = (cnt[1] != 2'd0);
    assign bus.out_0_data  = mem[0][rd_ptr[0]];
    assign bus.out_1_data  = mem[1][rd_ptr[1]];

    // Per-channel FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int e = 0; e < 2; e++) begin
                    mem[k][e] <= '0;
                end
                cnt[k]    <= 2'd0;
                rd_ptr[k] <= 1'b0;
                wr_ptr[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= bus.in_data;
                    wr_ptr[k]         <= ~wr_ptr[k];
                end
                if (pop[k]) begin
                    rd_ptr[k] <= ~rd_ptr[k];
                end
                if (push[k] && !pop[k]) begin
                    cnt[k] <= cnt[k] + 2'd1;
                end else if (!push[k] && pop[k]) begin
                    cnt[k] <= cnt[k] - 2'd1;
                end
            end
        end
    end

    // Alternating pointer advances only on beats accepted in auto mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (accept && bus.auto_mode) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Saturating count of cycles where the producer was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (bus.in_valid && !in_ready_w && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_demux_1x2_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_demux_1x2_buffered                                                |
// | Table-driven stimulus with a per-channel scoreboard and hand-written |
// | sequences for saturation and asynchronous reset.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_demux_1x2_buffered;
    typedef struct {
        logic       v;
        logic       s;
        logic       am;
        logic [7:0] d;
        logic       r0;
        logic       r1;
        logic       er;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_rr   = 1'b0;
    int         m_drop = 0;
    vec_t       tbl[$];

    demux_1x2_buffered_if #(.WIDTH(8)) bus ();

    demux_1x2_buffered #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic s, input logic am, input logic [7:0] d,
                       input logic r0, input logic r1, input logic er);
        vec_t t;
        t.v = v; t.s = s; t.am = am; t.d = d; t.r0 = r0; t.r1 = r1; t.er = er;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input logic s, input logic am, input logic [7:0] d,
                         input logic r0, input logic r1);
        @(posedge clk);
        #1;
        bus.in_valid    = v;
        bus.sel         = s;
        bus.auto_mode   = am;
        bus.in_data     = d;
        bus.out_0_ready = r0;
        bus.out_1_ready = r1;
    endtask

    // Scoreboard: observe each cycle mid-period, compare, then apply the
    // transfers the coming edge will perform.
    always @(negedge clk) begin : mon
        logic       t;
        logic       er;
        logic [7:0] tmp;
        if (rst_n === 1'b1) begin
            t  = bus.auto_mode ? m_rr : bus.sel;
            er = t ? (q1.size() < 2) : (q0.size() < 2);
            check("valid0", {31'd0, bus.out_0_valid}, {31'd0, q0.size() != 0});
            check("valid1", {31'd0, bus.out_1_valid}, {31'd0, q1.size() != 0});
            check("drop_cnt", {24'd0, drop_cnt}, m_drop);
            if (bus.in_valid)
                check("in_ready", {31'd0, bus.in_ready}, {31'd0, er});
            if (q0.size() != 0) begin
                check("data0", {24'd0, bus.out_0_data}, {24'd0, q0[0]});
                if (bus.out_0_ready) tmp = q0.pop_front();
            end
            if (q1.size() != 0) begin
                check("data1", {24'd0, bus.out_1_data}, {24'd0, q1[0]});
                if (bus.out_1_ready) tmp = q1.pop_front();
            end
            if (bus.in_valid && er) begin
                if (t) q1.push_back(bus.in_data);
                else   q0.push_back(bus.in_data);
                if (bus.auto_mode) m_rr = ~m_rr;
            end else if (bus.in_valid && m_drop != 255) begin
                m_drop++;
            end
        end
    end

    initial begin
        bus.in_valid = 0; bus.sel = 0; bus.auto_mode = 0; bus.in_data = 0;
        bus.out_0_ready = 0; bus.out_1_ready = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        check("rst_valid0", {31'd0, bus.out_0_valid}, 0);
        check("rst_valid1", {31'd0, bus.out_1_valid}, 0);
        check("rst_data0", {24'd0, bus.out_0_data}, 0);
        check("rst_data1", {24'd0, bus.out_1_data}, 0);
        check("rst_drop", {24'd0, drop_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // steer by sel
        add(1,0,0,8'h11,1,1,1); add(1,0,0,8'h22,1,1,1); add(1,1,0,8'h33,1,1,1);
        add(0,0,0,8'h00,1,1,1);
        // backpressure on ch0, then full-with-pop stall, then resume
        add(1,0,0,8'hA1,0,1,1); add(1,0,0,8'hA2,0,1,1); add(1,0,0,8'hA3,0,1,0);
        add(1,0,0,8'hA3,0,1,0); add(1,0,0,8'hA3,1,1,0); add(1,0,0,8'hA3,1,1,1);
        add(0,0,0,8'h00,1,1,1);
        // channel independence
        add(1,0,0,8'hC1,0,1,1); add(1,0,0,8'hC2,0,1,1); add(1,1,0,8'hB0,0,1,1);
        add(0,1,0,8'h00,0,1,1); add(0,0,0,8'h00,1,1,0); add(0,0,0,8'h00,1,1,1);
        // auto mode, sel toggling ignored; fifth beat proves pointer back at 0
        add(1,0,1,8'h01,1,1,1); add(1,1,1,8'h02,1,1,1); add(1,1,1,8'h03,1,1,1);
        add(1,0,1,8'h04,1,1,1); add(1,1,1,8'h05,1,1,1); add(0,0,0,8'h00,1,1,1);
        add(0,0,0,8'h00,1,1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].am, tbl[i].d, tbl[i].r0, tbl[i].r1);
            @(negedge clk);
            check($sformatf("tbl_ready[%0d]", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].er});
        end

        // drop counter saturation
        drive(1,0,0,8'h71,0,1);
        drive(1,0,0,8'h72,0,1);
        for (int i = 0; i < 260; i++) drive(1,0,0,8'h73,0,1);
        @(negedge clk);
        check("drop_sat", {24'd0, drop_cnt}, 255);
        for (int i = 0; i < 3; i++) drive(0,0,0,8'h00,1,1);

        // asynchronous reset with both channels holding data
        drive(1,0,0,8'h61,0,0);
        drive(1,1,0,8'h62,0,0);
        drive(1,0,0,8'h63,0,0);
        drive(1,0,0,8'h64,0,0);
        drive(1,0,0,8'h64,0,0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.in_valid = 0;
        #1;
        check("arst_valid0", {31'd0, bus.out_0_valid}, 0);
        check("arst_valid1", {31'd0, bus.out_1_valid}, 0);
        check("arst_data0", {24'd0, bus.out_0_data}, 0);
        check("arst_data1", {24'd0, bus.out_1_data}, 0);
        check("arst_drop", {24'd0, drop_cnt}, 0);
        check("arst_in_ready", {31'd0, bus.in_ready}, 1);
        q0.delete();
        q1.delete();
        m_drop = 0;
        m_rr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        drive(1,1,0,8'h5A,0,0);
        @(posedge clk);
        #1;
        check("lat_valid1", {31'd0, bus.out_1_valid}, 1);
        check("lat_data1", {24'd0, bus.out_1_data}, 8'h5A);
        check("lat_valid0", {31'd0, bus.out_0_valid}, 0);
        bus.in_valid    = 0;
        bus.out_1_ready = 1;
        for (int i = 0; i < 3; i++) drive(0,0,0,8'h00,1,1);
        @(negedge clk);
        check("end_q0_empty", q0.size(), 0);
        check("end_q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/demux_1x2_buffered.md
# demux_1x2_buffered

Sequential 1-to-2 demultiplexer: the inverse of the 2x1 mux. It takes a single valid/ready input stream and steers each accepted beat to one of two output channels. Each channel has its own 2-entry buffer with an independent valid/ready handshake. Steering follows `sel`, or an internal alternating pointer when `auto_mode` is high. The block sits between a shared producer and two independent consumers.

## Interface
- `WIDTH`, 8, data width of input and both outputs
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `in_data`  input  WIDTH  input beat
- `in_valid`  input  1  producer has a beat
- `in_ready`  output  1  block accepts beat this cycle
- `sel`  input  1  target channel (0 -> out_0, 1 -> out_1) when `auto_mode`=0
- `auto_mode`  input  1  1: ignore `sel`, alternate channels starting at the pointer value
- `out_0_data`  output  WIDTH  channel 0 head-of-buffer data
- `out_0_valid`  output  1  channel 0 buffer non-empty
- `out_0_ready`  input  1  channel 0 consumer takes head
- `out_1_data` / `out_1_valid` / `out_1_ready`: same as channel 0, for channel 1
- `drop_cnt`  output  8  count of cycles with `in_valid`=1 and `in_ready`=0 (stall counter), saturating

## Operation
- Target channel `tgt` = `auto_mode` ? `rr_ptr` : `sel`.
- `in_ready` = target buffer count < 2. It is combinational from `tgt` and the registered counts.
- Accept: `in_valid` && `in_ready`. The beat is written to the tail of the target buffer.
- `rr_ptr` toggles on every accept while `auto_mode`=1. It holds otherwise, including when `auto_mode`=0.
- Each channel has a 2-entry FIFO: two storage registers, a 1-bit read pointer, a 1-bit write pointer and a 2-bit count (0..2).
- Pop on channel k: `out_k_valid` && `out_k_ready`. The read pointer advances and count decrements.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
  - Allowed only when count < 2. At count 2, `in_ready`=0 for that target even if a pop occurs that cycle; there is no pass-through.
- `out_k_valid` = count_k != 0. `out_k_data` = entry at read pointer. Data is stable while valid && !ready.
- Beats within a channel leave in acceptance order. There is no ordering relation between channels.
- `drop_cnt` increments on each stall cycle (`in_valid`=1, `in_ready`=0) and saturates at 255.
- Changing `sel` or `auto_mode` mid-stream affects only beats not yet accepted.

## Timing
- Reset (async assert, synchronous-to-clk deassert assumed by upstream):
  - counts = 0, pointers = 0, `rr_ptr` = 0, `drop_cnt` = 0.
  - `out_0_valid` = `out_1_valid` = 0; `out_0_data` = `out_1_data` = 0 (storage cleared).
  - `in_ready` = 1.
- Reset asserted mid-operation: all buffered beats are discarded immediately, with no further outputs until new accepts.
- Latency: a beat accepted at edge N is visible on `out_k_data` with `out_k_valid`=1 after edge N (cycle N+1). This is 1 cycle if the buffer was empty.
- Throughput: 1 beat/cycle sustained into either channel while its consumer holds ready=1. A consumer stalled for 2 beats blocks only beats targeting its channel.
- In `auto_mode`, if the current target is full, input stalls; the pointer does not skip to the other channel.
- Pop and push take effect on the same edge. Count updates are visible the next cycle.

## Test plan
- Reset then steer: `sel`=0, push 0x11, 0x22; `sel`=1, push 0x33 with both readys=1.
  - out_0 shows 0x11 then 0x22, one cycle after each accept.
  - out_1 shows 0x33.
  - `drop_cnt`=0.
- Backpressure: `out_0_ready`=0, `sel`=0, push 0xA1, 0xA2, 0xA3.
  - First two accepted; `in_ready`=0 on the third and `drop_cnt` increments each stalled cycle.
  - Raise `out_0_ready`: 0xA1, 0xA2, 0xA3 delivered in order.
- Channel independence: out_0 full and stalled, `sel`=1, push 0xB0.
  - Accepted immediately; out_1 delivers 0xB0 next cycle.
- Auto mode: `auto_mode`=1, push 0x01..0x04 back-to-back, both readys=1.
  - out_0 gets 0x01, 0x03; out_1 gets 0x02, 0x04.
  - `rr_ptr`=0 at the end; `sel` toggling has no effect.
- Full with simultaneous pop: channel 0 count 2, `out_0_ready`=1, push to channel 0.
  - `in_ready`=0 that cycle; accepted the following cycle; order preserved.
- Async reset mid-stream: both buffers holding data, pull `rst_n` low between edges.
  - Valids drop to 0 and `drop_cnt`=0 without a clock edge.
  - After release, push 0x5A to channel 1: delivered after 1 cycle.
